inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the 16-bit pipeline. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned instructions go into a small prefetch buffer, which drives the instruction/PC pair into the IF/ID pipeline register. It absorbs downstream stalls and discards in-flight fetches on a branch redirect.

## Interface
- RESET_PC, 16'h0000, fetch address after reset
- ADDR_W, 16, instruction address width
- INST_W, 16, instruction width
- DEPTH, 2, prefetch buffer entries (power of two, ≥2)

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low (0 = reset)
- stall_i  in  1  downstream hold; head entry not consumed
- flush_i  in  1  redirect strobe from branch resolution
- flush_pc_i  in  ADDR_W  redirect target, sampled when flush_i=1
- imem_req_o  out  ADDR_W-independent 1  read request
- imem_addr_o  out  ADDR_W  read address, stable while imem_req_o=1
- imem_ack_i  in  1  read complete; imem_data_i valid this cycle
- imem_data_i  in  INST_W  read data
- if_inst_o  out  INST_W  instruction to IF/ID
- if_PC_o  out  ADDR_W  address of if_inst_o
- if_valid_o  out  1  if_inst_o/if_PC_o hold a real instruction

## Operation
- Registers:
  - fetch_pc: next address to request.
  - Buffer: DEPTH entries of {PC, inst}, with read/write pointers and a count.
  - State: IDLE, REQ, DROP.
- IDLE: imem_req_o=0.
  - Go to REQ when count_next < DEPTH.
- REQ: imem_req_o=1, imem_addr_o=fetch_pc.
  - imem_req_o and imem_addr_o are held until imem_ack_i=1 at an edge.
  - An ack in the same cycle as the request is legal (zero-wait memory).
- Ack in REQ, no flush:
  - Push {fetch_pc, imem_data_i} into the buffer.
  - fetch_pc <= fetch_pc+1 (word addressed; 16'hFFFF wraps to 16'h0000).
  - Stay in REQ if count_next < DEPTH, else go to IDLE.
- Pop: when if_valid_o=1 and stall_i=0, the head entry is removed.
  - Push and pop in the same cycle leave count unchanged.
- Outputs:
  - if_valid_o = (count != 0).
  - if_inst_o/if_PC_o = head entry when valid, 0 (NOP bubble) when empty.
- Flush has priority over push, pop and stall:
  - Buffer is cleared (count=0, pointers reset) and fetch_pc <= flush_pc_i.
  - REQ without ack in the flush cycle: go to DROP. The request stays asserted at the old address, since the handshake may not be abandoned.
  - REQ with ack in the flush cycle: the data is discarded and the block goes to REQ at flush_pc_i next cycle.
  - IDLE: go to REQ.
- DROP: imem_req_o=1 at the old address.
  - On ack, the data is discarded and the block goes to REQ, now at fetch_pc (the redirect target).
  - A flush while in DROP updates fetch_pc and the block remains in DROP.
- At most one memory request is outstanding at any time. The buffer never overflows; the count check guarantees this.

## Timing
- Reset (rst_i=0, asynchronous):
  - State=IDLE, fetch_pc=RESET_PC, count=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - if_valid_o=0, if_inst_o=0, if_PC_o=0.
- First imem_req_o=1 occurs in the first cycle after rst_i rises.
- Latency: an instruction acked at edge N is on if_inst_o with if_valid_o=1 from cycle N+1.
- Throughput: one instruction per cycle with zero-wait ack and stall_i=0.
- Redirect latency: flush at edge N → request for flush_pc_i in cycle N+1 if no request was outstanding; otherwise in the cycle after the outstanding ack.
  - if_valid_o=0 from cycle N+1 until the first redirected instruction arrives.
- Reset asserted mid-request drops the request immediately (imem_req_o=0 asynchronously).

## Test plan
- Reset release with zero-wait memory returning data=addr^16'hA5A5 → if_PC_o sequence 0,1,2,3 on consecutive cycles, if_inst_o=16'hA5A5,16'hA5A4,...; if_valid_o=1 from the 2nd cycle.
- stall_i=1 for 4 cycles with zero-wait memory:
  - Buffer fills to 2 and imem_req_o drops to 0.
  - if_PC_o holds its value.
  - After release, PCs continue without gap or duplicate.
- 3-cycle ack latency → imem_addr_o stable across all wait cycles; one instruction per 3 cycles.
- flush_i with flush_pc_i=16'h0040 while a request is outstanding (ack 2 cycles later):
  - Acked data is not output.
  - The next request is to 16'h0040, and if_PC_o=16'h0040 is the first valid output.
- RESET_PC=16'hFFFE → PCs FFFE, FFFF, 0000 (wrap).
- Flush and ack in the same cycle, with stall_i=1 → buffer empty next cycle, the next request goes to the target, and the acked data is discarded.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, runs a single-outstanding req/ack
// read master to instruction memory and buffers returned words for IF/ID.
module inst_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [INST_W-1:0] if_inst_o,
  output logic [ADDR_W-1:0] if_PC_o,
  output logic              if_valid_o
);

  localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZRO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZRO = {PTR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next_s;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic              push_s;
  logic              pop_s;
  logic              room_s;

  // A flush cancels both the pending push and the pop; the buffer is cleared instead.
  assign push_s = (state_q == S_REQ) && imem_ack_i && !flush_i;
  assign pop_s  = (count_q != CNT_ZRO) && !stall_i && !flush_i;
  assign room_s = (count_next_s < DEPTH_C);

  // Buffer occupancy after this cycle's push/pop, used to decide whether to keep fetching.
  always_comb begin
    count_next_s = count_q;
    if (push_s && !pop_s) begin
      count_next_s = count_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = count_q - CNT_ONE;
    end else begin
      count_next_s = count_q;
    end
  end

  // Fetch FSM, pointers, count and registered memory request outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      wr_ptr_q   <= PTR_ZRO;
      rd_ptr_q   <= PTR_ZRO;
      count_q    <= CNT_ZRO;
    end else if (flush_i) begin
      fetch_pc_q <= flush_pc_i;
      wr_ptr_q   <= PTR_ZRO;
      rd_ptr_q   <= PTR_ZRO;
      count_q    <= CNT_ZRO;
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          addr_q  <= flush_pc_i;
        end
        S_REQ, S_DROP: begin
          // An unacked handshake must complete at its old address before redirecting.
          if (imem_ack_i) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= flush_pc_i;
          end else begin
            state_q <= S_DROP;
            req_q   <= 1'b1;
            addr_q  <= addr_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          addr_q  <= flush_pc_i;
        end
      endcase
    end else begin
      count_q  <= count_next_s;
      wr_ptr_q <= push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_q <= pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case (state_q)
        S_IDLE: begin
          if (room_s) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
          addr_q <= fetch_pc_q;
        end
        S_REQ: begin
          if (imem_ack_i) begin
            fetch_pc_q <= fetch_pc_q + PC_ONE;
            addr_q     <= fetch_pc_q + PC_ONE;
            if (room_s) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
          end else begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= addr_q;
          end
        end
        S_DROP: begin
          if (imem_ack_i) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end else begin
            state_q <= S_DROP;
            req_q   <= 1'b1;
            addr_q  <= addr_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          addr_q  <= fetch_pc_q;
        end
      endcase
    end
  end

  // Prefetch buffer storage; entries are written only on an accepted push.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= {ADDR_W{1'b0}};
        inst_mem_q[i] <= {INST_W{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_data_i;
    end else begin
      pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
      inst_mem_q[wr_ptr_q] <= inst_mem_q[wr_ptr_q];
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = (count_q != CNT_ZRO);
  assign if_inst_o   = if_valid_o ? inst_mem_q[rd_ptr_q] : {INST_W{1'b0}};
  assign if_PC_o     = if_valid_o ? pc_mem_q[rd_ptr_q]   : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: memory returns addr^16'hA5A5 after a
// configurable number of wait cycles; expected PCs are queued per scenario.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush;
  logic [15:0] flush_pc;
  logic        req, ack, valid;
  logic [15:0] addr, data, inst, pc;

  logic        rst2, req2, ack2, valid2;
  logic [15:0] addr2, data2, inst2, pc2;

  int          lat;
  int          wait_cnt;
  int          checks;
  int          errors;
  logic [15:0] exp_q[$];

  inst_fetch u_dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .flush_pc_i(flush_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .if_inst_o(inst), .if_PC_o(pc), .if_valid_o(valid)
  );

  inst_fetch #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk_i(clk), .rst_i(rst2), .stall_i(1'b0), .flush_i(1'b0), .flush_pc_i(16'h0000),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_data_i(data2),
    .if_inst_o(inst2), .if_PC_o(pc2), .if_valid_o(valid2)
  );

  // Memory model: ack after 'lat' wait cycles of an asserted request.
  always @(negedge clk) begin
    if (req && rst_n) begin
      if (wait_cnt >= lat) begin
        ack = 1'b1; data = addr ^ 16'hA5A5; wait_cnt = 0;
      end else begin
        ack = 1'b0; wait_cnt = wait_cnt + 1;
      end
    end else begin
      ack = 1'b0; wait_cnt = 0;
    end
  end

  // Zero-wait memory for the wrap-around instance.
  always @(negedge clk) begin
    ack2  = req2 && rst2;
    data2 = addr2 ^ 16'hA5A5;
  end

  task automatic do_reset(input int l);
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; flush_pc = 16'h0000; lat = l;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
    checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL reset_inst got %h want 0000", inst); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
    checks++; if (addr2 !== 16'hFFFE) begin errors++; $display("FAIL reset_addr_wrap got %h want fffe", addr2); end
    checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL reset_req_wrap got %b want 0", req2); end
    do_reset(0);
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL midreq_reset_req got %b want 0", req); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midreq_reset_valid got %b want 0", valid); end
    @(negedge clk);
  endtask

  task automatic test_stream;
    logic [15:0] e;
    bit seen = 1'b0;
    do_reset(0);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_latency got valid %b want 0", valid); end
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (seen) begin
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_throughput got valid %b want 1", valid); end
      end
      if (valid && !stall) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (pc !== e || inst !== (e ^ 16'hA5A5)) begin
          errors++; $display("FAIL stream_out got pc=%h inst=%h want pc=%h inst=%h", pc, inst, e, e ^ 16'hA5A5);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    logic [15:0] e, held;
    int fv = -1;
    int j;
    do_reset(0);
    held = 16'h0000;
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (fv < 0 && valid) fv = c;
      j = (fv < 0) ? -1 : c - (fv + 2);
      stall = (j >= 0 && j < 4);
      if (stall) begin
        if (j == 0) held = pc;
        else begin
          checks++; if (pc !== held) begin errors++; $display("FAIL stall_hold got pc=%h want %h", pc, held); end
          checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", req); end
        end
      end
      if (valid && !stall) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e || inst !== (e ^ 16'hA5A5)) begin
          errors++; $display("FAIL stall_out got pc=%h inst=%h want pc=%h inst=%h", pc, inst, e, e ^ 16'hA5A5);
        end
      end
    end
    stall = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_latency;
    logic [15:0] e, run_addr;
    bit run_ok = 1'b0;
    int run_len = 0;
    int last = -1;
    do_reset(2);
    run_addr = 16'h0000;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (req) begin
        if (!run_ok || addr !== run_addr) begin
          if (run_ok) begin
            checks++; if (run_len != 3) begin errors++; $display("FAIL lat_addr_hold got %0d cycles want 3", run_len); end
          end
          run_ok = 1'b1; run_addr = addr; run_len = 1;
        end else run_len++;
      end
      if (valid && !stall) begin
        if (last >= 0) begin
          checks++; if (c - last != 3) begin errors++; $display("FAIL lat_rate got %0d cycles want 3", c - last); end
        end
        last = c;
        e = exp_q.pop_front();
        checks++;
        if (pc !== e || inst !== (e ^ 16'hA5A5)) begin
          errors++; $display("FAIL lat_out got pc=%h inst=%h want pc=%h inst=%h", pc, inst, e, e ^ 16'hA5A5);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lat_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_flush_outstanding;
    logic [15:0] e;
    do_reset(2);
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL fo_req got %b want 1", req); end
    flush = 1'b1; flush_pc = 16'h0040;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 16'h0000) begin errors++; $display("FAIL fo_drop_addr got req=%b addr=%h want 1 0000", req, addr); end
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 16'h0000) begin errors++; $display("FAIL fo_ack_addr got req=%b addr=%h want 1 0000", req, addr); end
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 16'h0040) begin errors++; $display("FAIL fo_redirect got req=%b addr=%h want 1 0040", req, addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fo_valid got %b want 0", valid); end
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0040 + 16'(i));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (valid && !stall) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e || inst !== (e ^ 16'hA5A5)) begin
          errors++; $display("FAIL fo_out got pc=%h inst=%h want pc=%h inst=%h", pc, inst, e, e ^ 16'hA5A5);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fo_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_flush_ack_stall;
    logic [15:0] e;
    do_reset(0);
    stall = 1'b1;
    for (int k = 0; k < 10 && !valid; k++) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fa_fill got valid %b want 1", valid); end
    flush = 1'b1; flush_pc = 16'h0080;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fa_empty got valid %b want 0", valid); end
    checks++; if (pc !== 16'h0000 || inst !== 16'h0000) begin errors++; $display("FAIL fa_bubble got pc=%h inst=%h want 0000 0000", pc, inst); end
    checks++; if (req !== 1'b1 || addr !== 16'h0080) begin errors++; $display("FAIL fa_target got req=%b addr=%h want 1 0080", req, addr); end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0080 + 16'(i));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (valid && !stall) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e || inst !== (e ^ 16'hA5A5)) begin
          errors++; $display("FAIL fa_out got pc=%h inst=%h want pc=%h inst=%h", pc, inst, e, e ^ 16'hA5A5);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fa_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    logic [15:0] e;
    exp_q.delete();
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    @(negedge clk);
    rst2 = 1'b1;
    for (int c = 0; c < 15 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (valid2) begin
        e = exp_q.pop_front();
        checks++;
        if (pc2 !== e || inst2 !== (e ^ 16'hA5A5)) begin
          errors++; $display("FAIL wrap_out got pc=%h inst=%h want pc=%h inst=%h", pc2, inst2, e, e ^ 16'hA5A5);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; rst2 = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 16'h0000;
    lat = 0; wait_cnt = 0; ack = 1'b0; data = 16'h0000; ack2 = 1'b0; data2 = 16'h0000;
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_flush_outstanding();
    test_flush_ack_stall();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
